// File: rtl/score_bcd_display_if.sv
// Bus between the score counter (master) and the BCD 7-segment display (slave).
// Signal names keep the board-level port names of the display block.
interface score_bcd_display_if #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
);
    logic [BIN_W-1:0]    i_Value;
    logic [7*DIGITS-1:0] o_Segments;
    logic                o_Overflow;
    logic                o_Busy;
    logic                o_Update;

    modport master (
        output i_Value,
        input  o_Segments, o_Overflow, o_Busy, o_Update
    );

    modport slave (
        input  i_Value,
        output o_Segments, o_Overflow, o_Busy, o_Update
    );
endinterface

// File: rtl/score_bcd_display.sv
// Binary score -> DIGITS 7-segment digits through a sequential double-dabble
// engine; reconverts only on a value change, saturates at all nines.
module score_bcd_display #(
    parameter int BIN_W      = 7,
    parameter int DIGITS     = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input logic                i_Clk,
    input logic                i_Rst_L,
    score_bcd_display_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;
    localparam int DEC_W = $clog2(10 ** DIGITS);
    localparam int CMP_W = (BIN_W > DEC_W) ? BIN_W : DEC_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [CMP_W-1:0] MAX_VAL  = CMP_W'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [SEG_W-1:0] SEG_OFF  = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_ENCODE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic [BIN_W-1:0] last_q, last_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             upd_q, upd_d;

    logic [CMP_W-1:0] value_wide;
    logic [BCD_W-1:0] bcd_adj;
    logic [SEG_W-1:0] seg_enc;
    logic             lead_zero;
    logic [6:0]       pat;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_of = 7'h7E;
            4'd1:    seg_of = 7'h30;
            4'd2:    seg_of = 7'h6D;
            4'd3:    seg_of = 7'h79;
            4'd4:    seg_of = 7'h33;
            4'd5:    seg_of = 7'h5B;
            4'd6:    seg_of = 7'h5F;
            4'd7:    seg_of = 7'h70;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h7B;
            default: seg_of = 7'h00;
        endcase
    endfunction

    assign value_wide = CMP_W'(bus.i_Value);

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    // Scan from the most significant digit; the units digit is never blanked.
    always_comb begin
        seg_enc   = '0;
        lead_zero = 1'b1;
        pat       = 7'h00;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            lead_zero = lead_zero & (bcd_q[4*d +: 4] == 4'd0);
            pat       = seg_of(bcd_q[4*d +: 4]);
            if (BLANK_LZ != 0 && d != 0 && lead_zero) pat = 7'h00;
            seg_enc[7*d +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        last_d     = last_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        seg_d      = seg_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        upd_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // last_q holds the raw input so a saturated value is not reconverted.
                if (pending_q || bus.i_Value != last_q) begin
                    last_d = bus.i_Value;
                    if (value_wide > MAX_VAL) begin
                        bin_d      = BIN_W'(MAX_VAL);
                        ovf_pend_d = 1'b1;
                    end else begin
                        bin_d      = bus.i_Value;
                        ovf_pend_d = 1'b0;
                    end
                    bcd_d     = '0;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = ST_ENCODE;
            end
            ST_ENCODE: begin
                seg_d   = seg_enc;
                ovf_d   = ovf_pend_q;
                upd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b1;
            last_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            seg_q      <= SEG_OFF;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_q     <= last_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            seg_q      <= seg_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            upd_q      <= upd_d;
        end
    end

    assign bus.o_Segments = seg_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Update   = upd_q;
endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench: default board build (dut a) and a 3-digit active-high
// build without blanking (dut b); every o_Update is scored against a decimal model.
module tb_score_bcd_display;
    typedef struct {
        logic [55:0] seg;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;
    int upd_a_cnt   = 0;
    int upd_b_cnt   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a_e;
    exp_t mon_b_e;

    score_bcd_display_if #(.BIN_W(7),  .DIGITS(2)) a_if ();
    score_bcd_display_if #(.BIN_W(10), .DIGITS(3)) b_if ();

    score_bcd_display #(.BIN_W(7), .DIGITS(2), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_a (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (a_if)
    );

    score_bcd_display #(.BIN_W(10), .DIGITS(3), .ACTIVE_LOW(0), .BLANK_LZ(0)) u_b (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: divide by powers of ten, look up patterns, blank leading zeros.
    function automatic logic [55:0] model_seg(input int value, input int digits,
                                              input bit al, input bit blz);
        logic [6:0]  tbl [10];
        logic [55:0] r;
        logic [6:0]  p;
        int          n;
        int          hi;
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        n   = (value > 10 ** digits - 1) ? 10 ** digits - 1 : value;
        r   = '0;
        for (int d = 0; d < digits; d++) begin
            hi = n / (10 ** d);
            p  = tbl[hi % 10];
            if (blz && d > 0 && hi == 0) p = 7'h00;
            r[7*d +: 7] = al ? ~p : p;
        end
        return r;
    endfunction

    task automatic push_a(input int value);
        exp_t e;
        e.seg = model_seg(value, 2, 1'b1, 1'b1);
        e.ovf = (value > 99);
        q_a.push_back(e);
    endtask

    task automatic push_b(input int value);
        exp_t e;
        e.seg = model_seg(value, 3, 1'b0, 1'b0);
        e.ovf = (value > 999);
        q_b.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: pop one expectation per o_Update pulse; a pulse with nothing queued is an error.
    always @(negedge clk) begin
        if (a_if.o_Update === 1'b1) begin
            upd_a_cnt++;
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL dut_a_unexpected_update: seg=%h ovf=%b, no update was due",
                         a_if.o_Segments, a_if.o_Overflow);
            end else begin
                mon_a_e = q_a.pop_front();
                if (a_if.o_Segments !== mon_a_e.seg[13:0] || a_if.o_Overflow !== mon_a_e.ovf) begin
                    miscompares++;
                    $display("FAIL dut_a_update: seg=%h ovf=%b, expected seg=%h ovf=%b",
                             a_if.o_Segments, a_if.o_Overflow, mon_a_e.seg[13:0], mon_a_e.ovf);
                end
            end
        end
        if (b_if.o_Update === 1'b1) begin
            upd_b_cnt++;
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL dut_b_unexpected_update: seg=%h ovf=%b, no update was due",
                         b_if.o_Segments, b_if.o_Overflow);
            end else begin
                mon_b_e = q_b.pop_front();
                if (b_if.o_Segments !== mon_b_e.seg[20:0] || b_if.o_Overflow !== mon_b_e.ovf) begin
                    miscompares++;
                    $display("FAIL dut_b_update: seg=%h ovf=%b, expected seg=%h ovf=%b",
                             b_if.o_Segments, b_if.o_Overflow, mon_b_e.seg[20:0], mon_b_e.ovf);
                end
            end
        end
    end

    task automatic drain(input int budget, input string what);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: pending a=%0d b=%0d after %0d cycles, expected 0 0",
                     what, q_a.size(), q_b.size(), budget);
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic test_reset();
        int a_lat;
        int b_lat;
        a_if.i_Value = 7'd0;
        b_if.i_Value = 10'd7;
        repeat (2) tick();
        vectors += 3;
        if (a_if.o_Segments !== 14'h3FFF) begin
            miscompares++;
            $display("FAIL reset_a_segments: got %h, expected 3fff", a_if.o_Segments);
        end
        if (b_if.o_Segments !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_b_segments: got %h, expected 0", b_if.o_Segments);
        end
        if ({a_if.o_Busy, a_if.o_Update, a_if.o_Overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_a_flags: busy/upd/ovf=%b, expected 000",
                     {a_if.o_Busy, a_if.o_Update, a_if.o_Overflow});
        end
        push_a(0);
        push_b(7);
        rst_n = 1'b1;
        a_lat = -1;
        b_lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (a_lat < 0 && a_if.o_Update === 1'b1) a_lat = n;
            if (b_lat < 0 && b_if.o_Update === 1'b1) b_lat = n;
        end
        vectors += 2;
        if (a_lat != 9) begin
            miscompares++;
            $display("FAIL reset_a_latency: update after %0d cycles, expected 9", a_lat);
        end
        if (b_lat != 12) begin
            miscompares++;
            $display("FAIL reset_b_latency: update after %0d cycles, expected 12", b_lat);
        end
        drain(5, "reset");
    endtask

    task automatic test_convert();
        logic [13:0] seg_before;
        int          busy_cnt;
        bit          stable;
        seg_before   = a_if.o_Segments;
        busy_cnt     = 0;
        stable       = 1'b1;
        a_if.i_Value = 7'd42;
        push_a(42);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (a_if.o_Busy === 1'b1) begin
                busy_cnt++;
                if (a_if.o_Segments !== seg_before) stable = 1'b0;
            end
            if (a_if.o_Update === 1'b1) break;
        end
        vectors += 2;
        if (busy_cnt != 8) begin
            miscompares++;
            $display("FAIL convert_busy_cycles: busy for %0d cycles, expected 8", busy_cnt);
        end
        if (!stable) begin
            miscompares++;
            $display("FAIL convert_stable: segments changed during conversion, expected %h held",
                     seg_before);
        end
        drain(20, "convert");
    endtask

    task automatic test_saturate();
        a_if.i_Value = 7'd99;
        push_a(99);
        drain(20, "sat_99");
        vectors++;
        if (a_if.o_Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_99_overflow: got %b, expected 0", a_if.o_Overflow);
        end
        a_if.i_Value = 7'd127;
        push_a(127);
        drain(20, "sat_127");
        vectors++;
        if (a_if.o_Overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_127_overflow: got %b, expected 1", a_if.o_Overflow);
        end
    endtask

    task automatic test_back_to_back();
        int start_cnt;
        a_if.i_Value = 7'd5;
        push_a(5);
        drain(20, "b2b_5");
        start_cnt    = upd_a_cnt;
        a_if.i_Value = 7'd37;
        push_a(37);
        repeat (3) tick();
        a_if.i_Value = 7'd61;
        push_a(61);
        drain(40, "b2b_37_61");
        repeat (15) tick();
        vectors++;
        if (upd_a_cnt - start_cnt != 2) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: %0d update pulses, expected 2", upd_a_cnt - start_cnt);
        end
    endtask

    task automatic test_wide();
        b_if.i_Value = 10'd1000;
        push_b(1000);
        drain(20, "wide_1000");
        vectors++;
        if (b_if.o_Overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_1000_overflow: got %b, expected 1", b_if.o_Overflow);
        end
        b_if.i_Value = 10'd0;
        push_b(0);
        drain(20, "wide_0");
        vectors++;
        if (b_if.o_Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_0_overflow: got %b, expected 0", b_if.o_Overflow);
        end
    endtask

    task automatic test_reset_mid();
        a_if.i_Value = 7'd88;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (a_if.o_Segments !== 14'h3FFF) begin
            miscompares++;
            $display("FAIL midreset_a_segments: got %h, expected 3fff", a_if.o_Segments);
        end
        if ({a_if.o_Busy, a_if.o_Update, a_if.o_Overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_a_flags: busy/upd/ovf=%b, expected 000",
                     {a_if.o_Busy, a_if.o_Update, a_if.o_Overflow});
        end
        if (b_if.o_Segments !== 21'h0) begin
            miscompares++;
            $display("FAIL midreset_b_segments: got %h, expected 0", b_if.o_Segments);
        end
        tick();
        push_a(88);
        push_b(0);
        rst_n = 1'b1;
        drain(30, "midreset_rerun");
        vectors++;
        if (a_if.o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_busy_after: got %b, expected 0", a_if.o_Busy);
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        a_if.i_Value = '0;
        b_if.i_Value = '0;
        #2 rst_n = 1'b0;
        test_reset();
        test_convert();
        test_saturate();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
